// File: rtl/register_file_pkg.sv
// Shared constants and vector types for the register file.
// Vectors are big-endian: bit 0 is the MSB.
package register_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef logic [0:DATA_W-1] reg_word_t;
endpackage

// File: rtl/register_file_if.sv
// Bundle of the register file's bus signals.
// Decode drives the write port and the read specifiers; the register file returns read data.
interface register_file_if;
  import register_file_pkg::*;

  logic      write;
  reg_word_t reg_data;
  reg_addr_t register_no;
  reg_addr_t readReg1;
  reg_addr_t readReg2;
  reg_word_t readData1;
  reg_word_t readData2;

  modport master (
    output write, reg_data, register_no, readReg1, readReg2,
    input  readData1, readData2
  );

  modport slave (
    input  write, reg_data, register_no, readReg1, readReg2,
    output readData1, readData2
  );
endinterface

// File: rtl/register_file_rf_read_mux.sv
// One asynchronous read port: selects a single word out of the register array.
module rf_read_mux
  import register_file_pkg::*;
(
  input  reg_word_t i_regs [NUM_REGS],
  input  reg_addr_t i_addr,
  output reg_word_t o_data
);
  // The address is used by value, so its big-endian bit order has no effect here.
  assign o_data = i_regs[i_addr];
endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: one synchronous write port and two combinational read ports.
// Reads return the stored value only; a same-cycle write becomes visible after the edge.
module register_file
  import register_file_pkg::*;
(
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);
  reg_word_t r_regs [NUM_REGS];
  reg_word_t w_rd1;
  reg_word_t w_rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.write) begin
      r_regs[bus.register_no] <= bus.reg_data;
    end
  end

  rf_read_mux u_rd1 (
    .i_regs (r_regs),
    .i_addr (bus.readReg1),
    .o_data (w_rd1)
  );

  rf_read_mux u_rd2 (
    .i_regs (r_regs),
    .i_addr (bus.readReg2),
    .o_data (w_rd2)
  );

  assign bus.readData1 = w_rd1;
  assign bus.readData2 = w_rd2;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read data, monitor pops and checks.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst;
  register_file_if u_if ();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int        id;
    reg_addr_t a1;
    reg_addr_t a2;
    reg_word_t e1;
    reg_word_t e2;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req;
  int   n_tests;
  int   n_fail;
  int   vec_id;

  // Monitor: samples read ports mid-cycle whenever stimulus presents a read.
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: read presented with no expected entry");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (u_if.readData1 !== e.e1) begin
          n_fail++;
          $display("FAIL rd1 vec%0d addr=%0d: got %h expected %h", e.id, e.a1, u_if.readData1, e.e1);
        end
        n_tests++;
        if (u_if.readData2 !== e.e2) begin
          n_fail++;
          $display("FAIL rd2 vec%0d addr=%0d: got %h expected %h", e.id, e.a2, u_if.readData2, e.e2);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic check_rd(input reg_addr_t a1, input reg_addr_t a2,
                          input reg_word_t e1, input reg_word_t e2);
    exp_t e;
    u_if.readReg1 = a1;
    u_if.readReg2 = a2;
    e.id = vec_id;
    e.a1 = a1;
    e.a2 = a2;
    e.e1 = e1;
    e.e2 = e2;
    sb_q.push_back(e);
    vec_id++;
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input logic r, input logic we, input reg_addr_t a, input reg_word_t d);
    rst              = r;
    u_if.write       = we;
    u_if.register_no = a;
    u_if.reg_data    = d;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    u_if.write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    vec_id           = 0;
    chk_req          = 1'b0;
    rst              = 1'b0;
    u_if.write       = 1'b0;
    u_if.reg_data    = '0;
    u_if.register_no = '0;
    u_if.readReg1    = '0;
    u_if.readReg2    = '0;
    @(posedge clk);
    #1;

    // Reset clears every register.
    do_cycle(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < NUM_REGS; i++)
      check_rd(reg_addr_t'(i), reg_addr_t'(31 - i), 32'h0, 32'h0);

    // Fill registers 1..31 with n-1.
    for (int n = 1; n < NUM_REGS; n++)
      do_cycle(1'b0, 1'b1, reg_addr_t'(n), reg_word_t'(n - 1));
    for (int n = 1; n < NUM_REGS; n++)
      check_rd(reg_addr_t'(n), 5'd0, reg_word_t'(n - 1), 32'h0);

    // Register 0 is writable.
    do_cycle(1'b0, 1'b1, 5'd0, 32'h39CE7F9E);
    check_rd(5'd0, 5'd2, 32'h39CE7F9E, 32'h1);
    do_cycle(1'b0, 1'b1, 5'd1, 32'hC0100420);
    check_rd(5'd0, 5'd1, 32'h39CE7F9E, 32'hC0100420);

    // Independent dual reads, including both ports on one address.
    check_rd(5'd8,  5'd17, 32'd7,  32'd16);
    check_rd(5'd10, 5'd31, 32'd9,  32'd30);
    check_rd(5'd12, 5'd12, 32'd11, 32'd11);
    check_rd(5'd31, 5'd1,  32'd30, 32'hC0100420);

    // write=0 leaves contents untouched.
    do_cycle(1'b0, 1'b0, 5'd5, 32'hDEADBEEF);
    check_rd(5'd5, 5'd4, 32'd4, 32'd3);

    // Same-register write: old value before the edge, new value after.
    u_if.write       = 1'b1;
    u_if.register_no = 5'd5;
    u_if.reg_data    = 32'hA5A50F0F;
    check_rd(5'd5, 5'd5, 32'd4, 32'd4);
    u_if.write = 1'b0;
    check_rd(5'd5, 5'd6, 32'hA5A50F0F, 32'd5);

    // Reset wins over a simultaneous write.
    do_cycle(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF);
    check_rd(5'd3, 5'd5, 32'h0, 32'h0);
    check_rd(5'd0, 5'd31, 32'h0, 32'h0);

    @(posedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
